// File: rtl/reaction_game_ctrl_if.sv
// Panel-side signals of the reaction game: buttons and switch in, lamp and displays out.
// master = round controller, slave = front panel / environment.
interface reaction_game_ctrl_if #(
   parameter int TW = 24
);
   logic          start_btn;
   logic          react_btn;
   logic          clear_sw;
   logic          led_go;
   logic [TW-1:0] timecount;
   logic [TW-1:0] hs;
   logic          false_start;
   logic          timeout;
   logic          new_record;
   logic [2:0]    state;

   modport master (
      input  start_btn, react_btn, clear_sw,
      output led_go, timecount, hs, false_start, timeout, new_record, state
   );

   modport slave (
      output start_btn, react_btn, clear_sw,
      input  led_go, timecount, hs, false_start, timeout, new_record, state
   );
endinterface

// File: rtl/reaction_game_ctrl.sv
// Reaction timer round sequencer: random wait, GO lamp, tick counting, foul/timeout
// detection and lowest-time high score with switch clear. All outputs registered.
module reaction_game_ctrl #(
   parameter int TW        = 24,
   parameter int TICK_DIV  = 50000,
   parameter int DELAY_MIN = 1000,
   parameter int DLY_BITS  = 11
) (
   input  logic                 clk,
   input  logic                 reset,
   reaction_game_ctrl_if.master bus
);
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ARM  = 3'd1,
      GO   = 3'd2,
      DONE = 3'd3,
      FOUL = 3'd4
   } state_t;

   localparam int PW = $clog2(TICK_DIV + 1);
   localparam int DW = $clog2(DELAY_MIN + 2**DLY_BITS + 1);
   localparam logic [TW-1:0] TC_MAX = '1;

   state_t        st;
   logic [PW-1:0] presc;
   logic [DW-1:0] delay_cnt;
   logic [15:0]   lfsr;
   logic          start_q, react_q, clear_q;
   logic [TW-1:0] tc, hs_r;
   logic          led, fs, to, nr;

   logic          start_p, react_p, clear_p, tick;
   logic [DW-1:0] delay_load;

   assign start_p    = bus.start_btn & ~start_q;
   assign react_p    = bus.react_btn & ~react_q;
   assign clear_p    = bus.clear_sw  & ~clear_q;
   assign tick       = (presc == PW'(TICK_DIV - 1));
   assign delay_load = DW'(DELAY_MIN) + DW'(lfsr[DLY_BITS-1:0]);

   always_ff @(posedge clk) begin
      // Previous levels track the inputs even during reset, so a button held
      // through reset must be released before it can count as a press.
      start_q <= bus.start_btn;
      react_q <= bus.react_btn;
      clear_q <= bus.clear_sw;

      if (reset) begin
         st        <= IDLE;
         presc     <= '0;
         delay_cnt <= '0;
         lfsr      <= 16'hACE1;
         tc        <= '0;
         hs_r      <= '0;
         led       <= 1'b0;
         fs        <= 1'b0;
         to        <= 1'b0;
         nr        <= 1'b0;
      end else begin
         lfsr  <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         presc <= tick ? '0 : presc + 1'b1;

         case (st)
            IDLE, DONE, FOUL: begin
               if (start_p) begin
                  st        <= ARM;
                  presc     <= '0;
                  delay_cnt <= delay_load;
                  tc        <= '0;
                  led       <= 1'b0;
                  fs        <= 1'b0;
                  to        <= 1'b0;
                  nr        <= 1'b0;
               end
            end
            ARM: begin
               if (react_p) begin
                  st  <= FOUL;
                  fs  <= 1'b1;
                  led <= 1'b0;
               end else if (tick) begin
                  if (delay_cnt == DW'(1)) begin
                     st    <= GO;
                     led   <= 1'b1;
                     presc <= '0;
                  end else begin
                     delay_cnt <= delay_cnt - 1'b1;
                  end
               end
            end
            GO: begin
               // A press wins over a coincident tick, freezing the pre-increment count.
               if (react_p) begin
                  st  <= DONE;
                  led <= 1'b0;
                  if (tc != '0 && (hs_r == '0 || tc < hs_r)) begin
                     hs_r <= tc;
                     nr   <= 1'b1;
                  end
               end else if (tick) begin
                  if (tc == TC_MAX) begin
                     st  <= DONE;
                     led <= 1'b0;
                     to  <= 1'b1;
                  end else begin
                     tc <= tc + 1'b1;
                  end
               end
            end
            default: st <= IDLE;
         endcase

         if (clear_p) begin
            hs_r <= '0;
            nr   <= 1'b0;
         end
      end
   end

   assign bus.state       = st;
   assign bus.led_go      = led;
   assign bus.timecount   = tc;
   assign bus.hs          = hs_r;
   assign bus.false_start = fs;
   assign bus.timeout     = to;
   assign bus.new_record  = nr;
endmodule

// File: tb/tb_reaction_game_ctrl.sv
// Bench for reaction_game_ctrl: a TW=24 instance for round play and a TW=4 instance for the ceiling.
module tb_reaction_game_ctrl;
   localparam int TD   = 4;
   localparam int DMIN = 2;
   localparam int DB   = 2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0, react = 1'b0, clr = 1'b0;
   always #5 clk = ~clk;

   reaction_game_ctrl_if #(.TW(24)) bus ();
   reaction_game_ctrl_if #(.TW(4))  bus_t ();

   assign bus.start_btn   = start;
   assign bus.react_btn   = react;
   assign bus.clear_sw    = clr;
   assign bus_t.start_btn = start;
   assign bus_t.react_btn = react;
   assign bus_t.clear_sw  = clr;

   reaction_game_ctrl #(.TW(24), .TICK_DIV(TD), .DELAY_MIN(DMIN), .DLY_BITS(DB)) dut (
      .clk(clk), .reset(reset), .bus(bus));
   reaction_game_ctrl #(.TW(4), .TICK_DIV(TD), .DELAY_MIN(DMIN), .DLY_BITS(DB)) dut_t (
      .clk(clk), .reset(reset), .bus(bus_t));

   int errors = 0;
   int checks = 0;
   int best   = 0;   // reference high score: lowest nonzero reaction count seen
   logic [15:0] m_lfsr;

   // Reference random source: 16-bit Fibonacci LFSR, taps 16,14,13,11, seed ACE1.
   always @(posedge clk) begin
      if (reset) m_lfsr <= 16'hACE1;
      else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
   end

   // Called just after a falling edge; returns the wait in ticks the DUT will draw.
   task automatic press_start(output int d);
      d = DMIN + int'(m_lfsr[DB-1:0]);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_go(output int n);
      n = 0;
      while (bus.led_go !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (bus.led_go !== 1'b1) n = -1;
   endtask

   // One full round: start, random wait, react w cycles after GO is seen.
   task automatic round(input int w, input bit with_clr, input string tag);
      int d, n, exp_tc;
      bit exp_nr;
      press_start(d);
      checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL %s arm_state got=%0d exp=1", tag, bus.state); end
      checks++; if (bus.timecount !== 24'd0) begin errors++; $display("FAIL %s arm_tc got=%0d exp=0", tag, bus.timecount); end
      checks++; if ({bus.false_start, bus.timeout, bus.new_record, bus.led_go} !== 4'b0000) begin
         errors++; $display("FAIL %s arm_flags got=%b exp=0000", tag, {bus.false_start, bus.timeout, bus.new_record, bus.led_go}); end
      wait_go(n);
      checks++; if (n != TD * d) begin errors++; $display("FAIL %s go_delay got=%0d exp=%0d", tag, n, TD * d); end
      checks++; if (bus.state !== 3'd2) begin errors++; $display("FAIL %s go_state got=%0d exp=2", tag, bus.state); end
      repeat (w) @(negedge clk);
      react = 1'b1;
      if (with_clr) clr = 1'b1;
      @(negedge clk);
      react = 1'b0;
      // Ticks land every TD cycles after GO; a press on a tick sees the old count.
      exp_tc = w / TD;
      exp_nr = (exp_tc != 0) && (best == 0 || exp_tc < best);
      if (exp_nr) best = exp_tc;
      if (with_clr) begin best = 0; exp_nr = 1'b0; end
      checks++; if (bus.state !== 3'd3) begin errors++; $display("FAIL %s done_state got=%0d exp=3", tag, bus.state); end
      checks++; if (bus.timecount !== 24'(exp_tc)) begin errors++; $display("FAIL %s timecount got=%0d exp=%0d", tag, bus.timecount, exp_tc); end
      checks++; if (bus.hs !== 24'(best)) begin errors++; $display("FAIL %s hs got=%0d exp=%0d", tag, bus.hs, best); end
      checks++; if (bus.new_record !== exp_nr) begin errors++; $display("FAIL %s new_record got=%0d exp=%0d", tag, bus.new_record, exp_nr); end
      checks++; if (bus.led_go !== 1'b0) begin errors++; $display("FAIL %s done_led got=%0d exp=0", tag, bus.led_go); end
   endtask

   task automatic test_reset();
      start = 1'b1;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL rst_state got=%0d exp=0", bus.state); end
      checks++; if ({bus.led_go, bus.false_start, bus.timeout, bus.new_record} !== 4'b0000) begin
         errors++; $display("FAIL rst_flags got=%b exp=0000", {bus.led_go, bus.false_start, bus.timeout, bus.new_record}); end
      checks++; if (bus.timecount !== 24'd0) begin errors++; $display("FAIL rst_tc got=%0d exp=0", bus.timecount); end
      checks++; if (bus.hs !== 24'd0) begin errors++; $display("FAIL rst_hs got=%0d exp=0", bus.hs); end
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL held_start got=%0d exp=0", bus.state); end
      start = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_rounds();
      round(20, 1'b0, "round1");
      round(28, 1'b0, "round2");
      round(12, 1'b0, "round3");
      round(13, 1'b0, "round4_tie");
      react = 1'b1;
      @(negedge clk);
      react = 1'b0;
      @(negedge clk);
      checks++; if (bus.state !== 3'd3 || bus.timecount !== 24'd3) begin
         errors++; $display("FAIL done_react_ignored got=%0d/%0d exp=3/3", bus.state, bus.timecount); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 6; i++) round(int'($urandom_range(0, 59)), 1'b0, "random");
   endtask

   task automatic test_foul();
      int d, k;
      bit saw_go;
      press_start(d);
      k = int'($urandom_range(0, TD * d - 2));
      repeat (k) @(negedge clk);
      react = 1'b1;
      @(negedge clk);
      react = 1'b0;
      checks++; if (bus.state !== 3'd4) begin errors++; $display("FAIL foul_state got=%0d exp=4", bus.state); end
      checks++; if (bus.false_start !== 1'b1) begin errors++; $display("FAIL foul_flag got=%0d exp=1", bus.false_start); end
      checks++; if (bus.hs !== 24'(best)) begin errors++; $display("FAIL foul_hs got=%0d exp=%0d", bus.hs, best); end
      saw_go = 1'b0;
      repeat (TD * d + 8) begin
         @(negedge clk);
         if (bus.led_go !== 1'b0) saw_go = 1'b1;
      end
      checks++; if (saw_go !== 1'b0) begin errors++; $display("FAIL foul_led got=%0d exp=0", saw_go); end
      press_start(d);
      checks++; if (bus.state !== 3'd1 || bus.false_start !== 1'b0) begin
         errors++; $display("FAIL foul_rearm got=%0d/%0d exp=1/0", bus.state, bus.false_start); end
      // React lands on the very tick that would have lit the lamp.
      repeat (TD * d - 1) @(negedge clk);
      react = 1'b1;
      @(negedge clk);
      react = 1'b0;
      checks++; if (bus.state !== 3'd4 || bus.led_go !== 1'b0) begin
         errors++; $display("FAIL foul_last_tick got=%0d/%0d exp=4/0", bus.state, bus.led_go); end
   endtask

   task automatic test_tick_coincide();
      round(19, 1'b0, "tick_coincide");
   endtask

   task automatic test_clear();
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      @(negedge clk);
      best = 0;
      checks++; if (bus.hs !== 24'd0) begin errors++; $display("FAIL clear_hs got=%0d exp=0", bus.hs); end
      round(8, 1'b1, "clear_coincide");
      round(24, 1'b0, "clear_held");
      clr = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_timeout();
      int d, n;
      press_start(d);
      wait_go(n);
      checks++; if (n != TD * d) begin errors++; $display("FAIL to_delay got=%0d exp=%0d", n, TD * d); end
      repeat (TD * 15) @(negedge clk);
      checks++; if (bus_t.timecount !== 4'd15 || bus_t.state !== 3'd2) begin
         errors++; $display("FAIL to_ceiling got=%0d/%0d exp=15/2", bus_t.timecount, bus_t.state); end
      repeat (TD) @(negedge clk);
      checks++; if (bus_t.state !== 3'd3 || bus_t.timeout !== 1'b1) begin
         errors++; $display("FAIL to_done got=%0d/%0d exp=3/1", bus_t.state, bus_t.timeout); end
      checks++; if (bus_t.timecount !== 4'd15 || bus_t.led_go !== 1'b0) begin
         errors++; $display("FAIL to_hold got=%0d/%0d exp=15/0", bus_t.timecount, bus_t.led_go); end
      checks++; if (bus_t.hs !== 4'(best) || bus_t.new_record !== 1'b0) begin
         errors++; $display("FAIL to_hs got=%0d/%0d exp=%0d/0", bus_t.hs, bus_t.new_record, best); end
   endtask

   task automatic test_reset_mid();
      checks++; if (bus.state !== 3'd2) begin errors++; $display("FAIL midrst_pre got=%0d exp=2", bus.state); end
      reset = 1'b1;
      @(negedge clk);
      checks++; if (bus.state !== 3'd0 || bus.led_go !== 1'b0) begin
         errors++; $display("FAIL midrst_state got=%0d/%0d exp=0/0", bus.state, bus.led_go); end
      checks++; if (bus.hs !== 24'd0 || bus.timecount !== 24'd0) begin
         errors++; $display("FAIL midrst_hs got=%0d/%0d exp=0/0", bus.hs, bus.timecount); end
      reset = 1'b0;
      best = 0;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_rounds();
      test_random();
      test_foul();
      test_tick_coincide();
      test_clear();
      test_timeout();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
